aclk_core: RTL and testbench

- Alarm clock core: keeps real-time HH:MM:SS in BCD, and holds one HH:MM alarm that can be armed.
- Sits on the far side of the alarm clock configuration/monitor interface. It consumes reset, H_in1/H_in0/M_in1/M_in0 and LD_time/LD_alarm, and drives the H/M/S output digits checked by the bench.
- Adds alarm arm/stop controls, an alarm output and an input-error pulse.

---
 rtl/aclk_pkg.sv | 35 +++
 rtl/aclk_bcd_digit.sv | 42 ++++
 rtl/aclk_core.sv | 128 ++++++++++++
 tb/tb_aclk_core.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared types, digit limits and load validation for the alarm clock core.
package aclk_pkg;

    localparam int unsigned SEC_TENS_MAX        = 5;
    localparam int unsigned MIN_TENS_MAX        = 5;
    localparam int unsigned HOUR_TENS_MAX       = 2;
    localparam int unsigned HOUR_UNITS_MAX_AT_2 = 3;
    localparam int unsigned UNITS_MAX           = 9;
    localparam int unsigned DIG_W               = 4;
    localparam int unsigned H1_W                = 2;

    typedef struct packed {
        logic [H1_W-1:0]  h1;
        logic [DIG_W-1:0] h0;
        logic [DIG_W-1:0] m1;
        logic [DIG_W-1:0] m0;
    } hhmm_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RING = 1'b1
    } alarm_state_e;

    // True when the digits form a legal 24-hour HH:MM.
    function automatic logic hhmm_valid(input hhmm_t t);
        logic ok;
        ok = (t.h1 <= H1_W'(HOUR_TENS_MAX)) && (t.h0 <= DIG_W'(UNITS_MAX)) &&
             (t.m1 <= DIG_W'(MIN_TENS_MAX)) && (t.m0 <= DIG_W'(UNITS_MAX));
        if ((t.h1 == H1_W'(HOUR_TENS_MAX)) && (t.h0 > DIG_W'(HOUR_UNITS_MAX_AT_2))) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/aclk_bcd_digit.sv
// One modulo-(MAX+1) BCD digit: advances on tick, load has priority, carries at MAX.
module aclk_bcd_digit #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt_c,
    output logic         carry_c
);

    logic [W-1:0] digit_q;
    logic [W-1:0] digit_d;

    always_comb begin
        carry_c = tick && (digit_q == W'(MAX));
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (carry_c) begin
            digit_d = '0;
        end else if (tick) begin
            digit_d = digit_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q     = digit_q;
    assign nxt_c = digit_d;

endmodule

// File: rtl/aclk_core.sv
// Alarm clock core: BCD HH:MM:SS timekeeping, loadable time/alarm, ringing alarm FSM.
module aclk_core
    import aclk_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [H1_W-1:0]  H_in1,
    input  logic [DIG_W-1:0] H_in0,
    input  logic [DIG_W-1:0] M_in1,
    input  logic [DIG_W-1:0] M_in0,
    input  logic             LD_time,
    input  logic             LD_alarm,
    input  logic             AL_ON,
    input  logic             STOP_al,
    output logic             Alarm,
    output logic             load_err,
    output logic [H1_W-1:0]  H_out1,
    output logic [DIG_W-1:0] H_out0,
    output logic [DIG_W-1:0] M_out1,
    output logic [DIG_W-1:0] M_out0,
    output logic [DIG_W-1:0] S_out1,
    output logic [DIG_W-1:0] S_out0
);

    localparam int unsigned PRESC_W = $clog2(TICKS_PER_SEC + 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    hhmm_t              alarm_reg_q, alarm_reg_d;
    logic               load_err_q, load_err_d;
    alarm_state_e       state_q, state_d;
    logic               alarm_q, alarm_d;

    hhmm_t              in_c, nxt_hhmm_c;
    logic               in_ok_c, ld_ok_c, sec_tick_c;
    logic               s0_carry_c, s1_carry_c, m0_carry_c, m1_carry_c, h0_carry_c, h1_carry_c;
    logic               hour_wrap_c, hour_load_c, enter_zero_c, match_c;
    logic [DIG_W-1:0]   s0_nxt_c, s1_nxt_c, m0_nxt_c, m1_nxt_c, h0_nxt_c;
    logic [H1_W-1:0]    h1_nxt_c;

    assign in_c       = hhmm_t'({H_in1, H_in0, M_in1, M_in0});
    assign in_ok_c    = hhmm_valid(in_c);
    assign ld_ok_c    = LD_time && in_ok_c;
    assign sec_tick_c = (presc_q == PRESC_W'(TICKS_PER_SEC - 1));

    // 23:59:59 rolls hours to 00; an h1 carry only follows an out-of-range hour.
    assign hour_wrap_c = (m1_carry_c && (H_out1 == H1_W'(HOUR_TENS_MAX)) &&
                          (H_out0 == DIG_W'(HOUR_UNITS_MAX_AT_2))) || h1_carry_c;
    assign hour_load_c = ld_ok_c || hour_wrap_c;

    aclk_bcd_digit #(.W(DIG_W), .MAX(UNITS_MAX)) u_s0 (
        .clk(clk), .reset_n(reset_n), .tick(sec_tick_c), .load(ld_ok_c),
        .load_val('0), .q(S_out0), .nxt_c(s0_nxt_c), .carry_c(s0_carry_c));
    aclk_bcd_digit #(.W(DIG_W), .MAX(SEC_TENS_MAX)) u_s1 (
        .clk(clk), .reset_n(reset_n), .tick(s0_carry_c), .load(ld_ok_c),
        .load_val('0), .q(S_out1), .nxt_c(s1_nxt_c), .carry_c(s1_carry_c));
    aclk_bcd_digit #(.W(DIG_W), .MAX(UNITS_MAX)) u_m0 (
        .clk(clk), .reset_n(reset_n), .tick(s1_carry_c), .load(ld_ok_c),
        .load_val(M_in0), .q(M_out0), .nxt_c(m0_nxt_c), .carry_c(m0_carry_c));
    aclk_bcd_digit #(.W(DIG_W), .MAX(MIN_TENS_MAX)) u_m1 (
        .clk(clk), .reset_n(reset_n), .tick(m0_carry_c), .load(ld_ok_c),
        .load_val(M_in1), .q(M_out1), .nxt_c(m1_nxt_c), .carry_c(m1_carry_c));
    aclk_bcd_digit #(.W(DIG_W), .MAX(UNITS_MAX)) u_h0 (
        .clk(clk), .reset_n(reset_n), .tick(m1_carry_c), .load(hour_load_c),
        .load_val(ld_ok_c ? H_in0 : DIG_W'(0)), .q(H_out0), .nxt_c(h0_nxt_c),
        .carry_c(h0_carry_c));
    aclk_bcd_digit #(.W(H1_W), .MAX(HOUR_TENS_MAX)) u_h1 (
        .clk(clk), .reset_n(reset_n), .tick(h0_carry_c), .load(hour_load_c),
        .load_val(ld_ok_c ? H_in1 : H1_W'(0)), .q(H_out1), .nxt_c(h1_nxt_c),
        .carry_c(h1_carry_c));

    // Match fires on the edge that lands the clock on HH:MM:00, by tick or by load.
    assign nxt_hhmm_c   = hhmm_t'({h1_nxt_c, h0_nxt_c, m1_nxt_c, m0_nxt_c});
    assign enter_zero_c = (ld_ok_c || sec_tick_c) && (s1_nxt_c == '0) && (s0_nxt_c == '0);
    assign match_c      = AL_ON && enter_zero_c && (nxt_hhmm_c == alarm_reg_q);

    always_comb begin
        presc_d     = presc_q + PRESC_W'(1);
        alarm_reg_d = alarm_reg_q;
        load_err_d  = (LD_time || LD_alarm) && !in_ok_c;
        if (ld_ok_c || sec_tick_c) begin
            presc_d = '0;
        end
        if (LD_alarm && in_ok_c) begin
            alarm_reg_d = in_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            alarm_reg_q <= '0;
            load_err_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            alarm_reg_q <= alarm_reg_d;
            load_err_q  <= load_err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (match_c && !STOP_al) state_d = RING;
            RING:    if (STOP_al || !AL_ON)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alarm_d = (state_d == RING);
    end

    assign Alarm    = alarm_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_aclk_core.sv
// Directed bench for aclk_core: counting, wrap, load rejection, alarm ring/stop, async reset.
module tb_aclk_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, AL_ON, STOP_al;
    logic       Alarm, load_err;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

    int n_checks = 0;
    int n_pass   = 0;

    aclk_core #(.TICKS_PER_SEC(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_ON(AL_ON), .STOP_al(STOP_al),
        .Alarm(Alarm), .load_err(load_err),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .S_out1(S_out1), .S_out0(S_out0));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int now_t();
        return int'({H_out1, H_out0, M_out1, M_out0, S_out1, S_out0});
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
        H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0;
    endtask

    initial begin
        reset_n = 1'b0; LD_time = 1'b0; LD_alarm = 1'b0; AL_ON = 1'b0; STOP_al = 1'b0;
        set_in(2'd0, 4'd0, 4'd0, 4'd0);
        @(posedge clk); #1;
        check("reset_time", now_t(), 24'h000000);
        check("reset_alarm", int'(Alarm), 0);
        check("reset_err", int'(load_err), 0);
        reset_n = 1'b1;

        // First second lands on edge 10, then every 10 edges
        step(9);     check("pre_tick", now_t(), 24'h000000);
        step(1);     check("tick_1s", now_t(), 24'h000001);
        step(10);    check("tick_2s", now_t(), 24'h000002);
        step(35980); check("one_hour", now_t(), 24'h010000);
        step(5);     check("one_hour_p5", now_t(), 24'h010000);

        // Full wrap 23:59:59 -> 00:00:00
        set_in(2'd2, 4'd3, 4'd5, 4'd9); LD_time = 1'b1;
        step(1); LD_time = 1'b0;
        check("ld_2359", now_t(), 24'h235900);
        check("ld_ok_err", int'(load_err), 0);
        step(599); check("pre_wrap", now_t(), 24'h235959);
        step(1);   check("day_wrap", now_t(), 24'h000000);

        // Rejected loads
        set_in(2'd2, 4'd4, 4'd0, 4'd0); LD_time = 1'b1;
        step(1); LD_time = 1'b0;
        check("bad_time_err", int'(load_err), 1);
        check("bad_time_keep", now_t(), 24'h000000);
        step(1); check("bad_time_pulse", int'(load_err), 0);
        set_in(2'd1, 4'd2, 4'd6, 4'd0); LD_alarm = 1'b1;
        step(1); LD_alarm = 1'b0;
        check("bad_alarm_err", int'(load_err), 1);
        step(1); check("bad_alarm_pulse", int'(load_err), 0);
        set_in(2'd1, 4'd9, 4'd7, 4'd5); LD_time = 1'b1; LD_alarm = 1'b1;
        step(1); LD_time = 1'b0; LD_alarm = 1'b0;
        check("bad_both_err", int'(load_err), 1);
        check("bad_both_keep", now_t(), 24'h000000);
        step(1); check("bad_both_pulse", int'(load_err), 0);

        // Alarm register still 00:00: loading time 00:00 with AL_ON rings
        AL_ON = 1'b1; set_in(2'd0, 4'd0, 4'd0, 4'd0); LD_time = 1'b1;
        step(1); LD_time = 1'b0;
        check("alarm_kept_ring", int'(Alarm), 1);
        STOP_al = 1'b1; step(1); STOP_al = 1'b0;
        check("stop_0000", int'(Alarm), 0);
        AL_ON = 1'b0;

        // Alarm at 07:30 reached by counting
        set_in(2'd0, 4'd7, 4'd3, 4'd0); LD_alarm = 1'b1;
        step(1); LD_alarm = 1'b0;
        check("ld_alarm_err", int'(load_err), 0);
        AL_ON = 1'b1; set_in(2'd0, 4'd7, 4'd2, 4'd9); LD_time = 1'b1;
        step(1); LD_time = 1'b0;
        check("ld_0729", now_t(), 24'h072900);
        check("no_ring_0729", int'(Alarm), 0);
        step(599); check("pre_0730", int'(Alarm), 0);
        step(1);
        check("at_0730", now_t(), 24'h073000);
        check("ring_0730", int'(Alarm), 1);
        STOP_al = 1'b1; step(1); STOP_al = 1'b0;
        check("stop_ring", int'(Alarm), 0);
        step(600);
        check("at_0731", now_t(), 24'h073100);
        check("silent_0731", int'(Alarm), 0);

        // AL_ON gating
        AL_ON = 1'b0; set_in(2'd0, 4'd7, 4'd3, 4'd0); LD_time = 1'b1;
        step(1);
        check("disarmed_match", int'(Alarm), 0);
        AL_ON = 1'b1; step(1); LD_time = 1'b0;
        check("armed_ld_match", int'(Alarm), 1);
        AL_ON = 1'b0; step(1);
        check("al_off_stops", int'(Alarm), 0);

        // Async reset while ringing at 07:30:05
        AL_ON = 1'b1; LD_time = 1'b1;
        step(1); LD_time = 1'b0;
        check("ring_again", int'(Alarm), 1);
        step(50);
        check("at_073005", now_t(), 24'h073005);
        check("ring_073005", int'(Alarm), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_alarm", int'(Alarm), 0);
        check("async_rst_time", now_t(), 24'h000000);
        #1 reset_n = 1'b1;

        // Alarm register back to 00:00; STOP wins over a same-cycle match
        set_in(2'd0, 4'd0, 4'd0, 4'd0); LD_time = 1'b1; STOP_al = 1'b1;
        step(1); STOP_al = 1'b0;
        check("stop_beats_match", int'(Alarm), 0);
        step(1); LD_time = 1'b0;
        check("rst_alarm_0000", int'(Alarm), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
